// File: rtl/sprite_update_sched_if.sv
// Sprite update scheduler bus: execute-side write request,
// vblank/ovf controls, and attribute table write port.
interface sprite_update_sched_if #(
  parameter int AW = 3
);
  logic          wr_en;
  logic [4:0]    sprite_sel;
  logic [9:0]    sprite_x;
  logic [8:0]    sprite_y;
  logic          sprite_vis;
  logic          sprite_attr;
  logic          sprite_pos;
  logic          vblank;
  logic          ovf_clr;
  logic          stall;
  logic          tbl_we;
  logic [4:0]    tbl_addr;
  logic [21:0]   tbl_data;
  logic [AW:0]   pending;
  logic          ovf;

  modport master (
    output wr_en, sprite_sel, sprite_x, sprite_y,
    output sprite_vis, sprite_attr, sprite_pos,
    output vblank, ovf_clr,
    input  stall, tbl_we, tbl_addr, tbl_data,
    input  pending, ovf
  );

  modport slave (
    input  wr_en, sprite_sel, sprite_x, sprite_y,
    input  sprite_vis, sprite_attr, sprite_pos,
    input  vblank, ovf_clr,
    output stall, tbl_we, tbl_addr, tbl_data,
    output pending, ovf
  );
endinterface

// File: rtl/sprite_update_sched.sv
// Queues sprite writes; applies them to the attribute table in vblank.
// Ports: clk, reset (sync, active-high), bus (slave): wr_en/sprite_*
// in, vblank, ovf_clr in; stall, tbl_we/addr/data, pending, ovf out.
// Optional: SCHED_COALESCE_EN merges a push into the newest queued
// entry when the sprite index matches.
module sprite_update_sched #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input logic                  clk,
  input logic                  reset,
  sprite_update_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VB,
    DRAIN
  } state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [26:0]   r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;
  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_tbl_we;
  logic [4:0]    r_tbl_addr;
  logic [21:0]   r_tbl_data;
  logic          r_ovf;

  logic          w_full;
  logic          w_pop;
  logic          w_coal;
  logic          w_push;
  logic          w_drop;
  logic [AW:0]   w_cnt_nxt;
  logic [AW-1:0] w_last;
  logic [26:0]   w_entry;

  assign w_entry = {bus.sprite_sel, bus.sprite_vis,
                    bus.sprite_attr, bus.sprite_pos,
                    bus.sprite_y, bus.sprite_x};
  assign w_full  = (r_count == FULL);
  assign w_last  = r_tail - AW'(1);
  assign w_pop   = (r_state == DRAIN) && bus.vblank
                && (r_count != '0);

`ifdef SCHED_COALESCE_EN
  // Merge into the newest entry unless it leaves the queue this cycle.
  assign w_coal = bus.wr_en && (r_count != '0)
               && (r_mem[w_last][26:22] == bus.sprite_sel)
               && !(w_pop && (r_count == (AW+1)'(1)));
`else
  assign w_coal = 1'b0;
`endif

  assign w_push = bus.wr_en && !w_coal && !w_full;
  assign w_drop = bus.wr_en && !w_coal && w_full;

  always_comb begin
    w_cnt_nxt = r_count;
    if (w_push && !w_pop)
      w_cnt_nxt = r_count + (AW+1)'(1);
    else if (w_pop && !w_push)
      w_cnt_nxt = r_count - (AW+1)'(1);
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:
        if (w_cnt_nxt != '0) w_state_nxt = WAIT_VB;
      WAIT_VB:
        if (w_cnt_nxt == '0) w_state_nxt = IDLE;
        else if (bus.vblank) w_state_nxt = DRAIN;
      DRAIN:
        if (w_cnt_nxt == '0) w_state_nxt = IDLE;
        else if (!bus.vblank) w_state_nxt = WAIT_VB;
      default:
        w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= w_entry;
    if (w_coal) r_mem[w_last] <= w_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_state    <= IDLE;
      r_tbl_we   <= 1'b0;
      r_tbl_addr <= '0;
      r_tbl_data <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_cnt_nxt;
      r_tbl_we <= w_pop;
      if (w_push) r_tail <= r_tail + AW'(1);
      if (w_pop) begin
        r_head     <= r_head + AW'(1);
        r_tbl_addr <= r_mem[r_head][26:22];
        r_tbl_data <= r_mem[r_head][21:0];
      end
      if (w_drop)           r_ovf <= 1'b1;
      else if (bus.ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign bus.stall    = w_full;
  assign bus.tbl_we   = r_tbl_we;
  assign bus.tbl_addr = r_tbl_addr;
  assign bus.tbl_data = r_tbl_data;
  assign bus.pending  = r_count;
  assign bus.ovf      = r_ovf;

endmodule

// File: tb/tb_sprite_update_sched.sv
// Self-checking bench for sprite_update_sched: queue model
// compared every cycle plus directed literal checks.
module tb_sprite_update_sched;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sprite_update_sched_if #(.AW(AW)) bus ();

  sprite_update_sched #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: a plain queue of {sel,vis,attr,pos,y,x}. Draining is
  // allowed on an edge only when the previous edge saw vblank high
  // with data already queued and data still queued after it.
  logic [26:0] mq[$];
  bit          m_drain = 1'b0;
  logic        m_we    = 1'b0;
  logic [4:0]  m_addr  = '0;
  logic [21:0] m_data  = '0;
  logic        m_ovf   = 1'b0;

  always @(posedge clk) begin
    int   c0;
    logic pop;
    logic [26:0] e;
    logic coal;
    e = {bus.sprite_sel, bus.sprite_vis, bus.sprite_attr,
         bus.sprite_pos, bus.sprite_y, bus.sprite_x};
    if (reset) begin
      mq.delete();
      m_drain = 0; m_we = 0; m_addr = '0;
      m_data = '0; m_ovf = 0;
    end else begin
      c0  = mq.size();
      pop = m_drain && bus.vblank && (c0 > 0);
      coal = 1'b0;
`ifdef SCHED_COALESCE_EN
      if (bus.wr_en && c0 > 0 && mq[c0-1][26:22] == bus.sprite_sel
          && !(pop && c0 == 1))
        coal = 1'b1;
`endif
      m_we = pop;
      if (pop) begin
        m_addr = mq[0][26:22];
        m_data = mq[0][21:0];
      end
      if (coal) mq[c0-1] = e;
      if (pop) void'(mq.pop_front());
      if (bus.wr_en && !coal) begin
        if (c0 == DEPTH) m_ovf = 1'b1;
        else mq.push_back(e);
      end
      if (!(bus.wr_en && !coal && c0 == DEPTH) && bus.ovf_clr)
        m_ovf = 1'b0;
      m_drain = bus.vblank && (c0 > 0) && (mq.size() > 0);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_stall",   32'(bus.stall),    32'(mq.size() == DEPTH));
      chk("m_pending", 32'(bus.pending),  32'(mq.size()));
      chk("m_tbl_we",  32'(bus.tbl_we),   32'(m_we));
      chk("m_addr",    32'(bus.tbl_addr), 32'(m_addr));
      chk("m_data",    32'(bus.tbl_data), 32'(m_data));
      chk("m_ovf",     32'(bus.ovf),      32'(m_ovf));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [4:0] s, input logic [9:0] x,
                      input logic [8:0] y, input logic v);
    bus.wr_en = 1'b1;
    bus.sprite_sel = s;
    bus.sprite_x = x;
    bus.sprite_y = y;
    bus.sprite_vis = v;
    tick();
    bus.wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int pulses;
    logic [4:0]  sa [8];
    logic [4:0]  l_addr;
    logic [21:0] l_data;
    logic [4:0]  exp5 [4];

    bus.wr_en = 0; bus.sprite_sel = '0; bus.sprite_x = '0;
    bus.sprite_y = '0; bus.sprite_vis = 0; bus.sprite_attr = 0;
    bus.sprite_pos = 0; bus.vblank = 0; bus.ovf_clr = 0;
    tick(); tick();
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_pending", 32'(bus.pending), 0);
    chk("rst_we", 32'(bus.tbl_we), 0);
    chk("rst_ovf", 32'(bus.ovf), 0);

    // single write, applied only once vblank arrives
    push(5'd3, 10'd100, 9'd50, 1'b1);
    chk("t1_pending", 32'(bus.pending), 1);
    tick(); tick();
    chk("t1_no_we", 32'(bus.tbl_we), 0);
    bus.vblank = 1'b1;
    pulses = 0; l_addr = '0; l_data = '0;
    repeat (6) begin
      tick();
      if (bus.tbl_we) begin
        pulses++; l_addr = bus.tbl_addr; l_data = bus.tbl_data;
      end
    end
    chk("t1_pulses", 32'(pulses), 1);
    chk("t1_addr", 32'(l_addr), 3);
    chk("t1_data", 32'(l_data), 32'h20C864);
    chk("t1_empty", 32'(bus.pending), 0);
    bus.vblank = 1'b0;
    tick();

    // fill, overflow, clear
    for (int i = 0; i < 8; i++)
      push(5'(i), 10'(i * 10), 9'(i + 1), 1'b1);
    chk("t2_stall", 32'(bus.stall), 1);
    chk("t2_pending", 32'(bus.pending), 8);
    push(5'd9, 10'd999, 9'd9, 1'b0);
    chk("t2_ovf", 32'(bus.ovf), 1);
    chk("t2_pending9", 32'(bus.pending), 8);
    bus.ovf_clr = 1'b1; tick(); bus.ovf_clr = 1'b0;
    chk("t2_ovf_clr", 32'(bus.ovf), 0);

    // short vblank: three pops
    bus.vblank = 1'b1;
    pulses = 0;
    repeat (4) begin
      tick();
      if (bus.tbl_we) begin sa[pulses] = bus.tbl_addr; pulses++; end
    end
    bus.vblank = 1'b0;
    tick();
    chk("t3_pulses", 32'(pulses), 3);
    for (int i = 0; i < 3; i++) chk("t3_sel", 32'(sa[i]), 32'(i));
    chk("t3_pending", 32'(bus.pending), 5);
    chk("t3_we_off", 32'(bus.tbl_we), 0);
    bus.vblank = 1'b1;
    pulses = 0;
    repeat (8) begin
      tick();
      if (bus.tbl_we) begin sa[pulses] = bus.tbl_addr; pulses++; end
    end
    bus.vblank = 1'b0;
    tick();
    chk("t3b_pulses", 32'(pulses), 5);
    for (int i = 0; i < 5; i++)
      chk("t3b_sel", 32'(sa[i]), 32'(i + 3));

    // push on the same edge as a pop
    for (int i = 0; i < 4; i++)
      push(5'(10 + i), 10'(i), 9'(i), 1'b1);
    bus.vblank = 1'b1;
    tick();
    push(5'd20, 10'd7, 9'd7, 1'b1);
    chk("t4_we0", 32'(bus.tbl_we), 1);
    chk("t4_addr0", 32'(bus.tbl_addr), 10);
    chk("t4_pending", 32'(bus.pending), 4);
    exp5[0] = 5'd11; exp5[1] = 5'd12;
    exp5[2] = 5'd13; exp5[3] = 5'd20;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t4_we", 32'(bus.tbl_we), 1);
      chk("t4_addr", 32'(bus.tbl_addr), 32'(exp5[k]));
    end
    tick();
    chk("t4_we_end", 32'(bus.tbl_we), 0);
    chk("t4_empty", 32'(bus.pending), 0);
    bus.vblank = 1'b0;
    tick();

    // reset in the middle of a drain
    for (int i = 0; i < 8; i++)
      push(5'(i), 10'(i), 9'(i), 1'b1);
    push(5'd9, 10'd9, 9'd9, 1'b1);
    chk("t5_ovf_set", 32'(bus.ovf), 1);
    bus.vblank = 1'b1;
    tick(); tick();
    chk("t5_draining", 32'(bus.tbl_we), 1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t5_we", 32'(bus.tbl_we), 0);
    chk("t5_pending", 32'(bus.pending), 0);
    chk("t5_ovf", 32'(bus.ovf), 0);
    chk("t5_stall", 32'(bus.stall), 0);
    pulses = 0;
    repeat (5) begin
      tick();
      if (bus.tbl_we) pulses++;
    end
    chk("t5_no_writes", 32'(pulses), 0);
    bus.vblank = 1'b0;
    tick();

`ifdef SCHED_COALESCE_EN
    push(5'd5, 10'd10, 9'd1, 1'b1);
    push(5'd5, 10'd20, 9'd1, 1'b1);
    chk("t6_pending", 32'(bus.pending), 1);
    bus.vblank = 1'b1;
    pulses = 0; l_data = '0;
    repeat (5) begin
      tick();
      if (bus.tbl_we) begin pulses++; l_data = bus.tbl_data; end
    end
    chk("t6_pulses", 32'(pulses), 1);
    chk("t6_x", 32'(l_data[9:0]), 20);
    bus.vblank = 1'b0;
    tick();
`endif

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_update_sched.md
Name: sprite_update_sched

Overview:
- Queues sprite register writes issued by the execute stage's sprite instruction and applies them to the sprite attribute table only during vertical blanking, so sprites never tear mid-frame.
- Sits between the execute-stage sprite outputs and the sprite attribute table write port.
- Provides a stall to the hazard unit when its queue is full.

Parameters:
- DEPTH, 8, queue entries; power of two, at least 2.
- AW, 3, pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  one-cycle write request; this is spriteE from execute.
- sprite_sel  in  5  target sprite index.
- sprite_x  in  10  sprite X position.
- sprite_y  in  9  sprite Y position.
- sprite_vis  in  1  visible flag.
- sprite_attr  in  1  attribute bit.
- sprite_pos  in  1  priority/position bit.
- vblank  in  1  high during vertical blanking; synchronous to clk.
- ovf_clr  in  1  clears ovf.
- stall  out  1  queue full; the hazard unit holds execute while this is high.
- tbl_we  out  1  attribute table write strobe.
- tbl_addr  out  5  attribute table address.
- tbl_data  out  22  packed entry {vis,attr,pos,y[8:0],x[9:0]}.
- pending  out  AW+1  number of queued entries, 0..DEPTH.
- ovf  out  1  sticky flag: a write was dropped.

Behaviour:
- Reset (synchronous, clk edge): queue emptied, pointers = 0, state = IDLE. stall, tbl_we, tbl_addr, tbl_data, pending, ovf all 0. An in-progress drain is abandoned and queued writes are lost.
- Queue: circular FIFO of DEPTH x 27-bit entries {sel,vis,attr,pos,y,x}. Head/tail pointers are AW bits and wrap modulo DEPTH. Count is held in a separate AW+1-bit register.
- Push: on an edge with wr_en=1 and count<DEPTH, the entry is written at tail, tail increments, count increments.
- Push while full: if wr_en=1 and count==DEPTH, the write is dropped and ovf is set. This applies even if a pop occurs in the same cycle.
- stall = (count==DEPTH). It is decoded combinationally from registered count.
- ovf: set as above. Cleared on the edge when ovf_clr=1 and no drop occurs that cycle; if a drop and ovf_clr coincide, set wins.
- FSM states:
  - IDLE: count==0. Go to WAIT_VB when count>0.
  - WAIT_VB: go to DRAIN when vblank=1. Go to IDLE if count==0.
  - DRAIN: on any cycle with vblank=1 and count>0, pop the head.
    - Next cycle: tbl_we=1, tbl_addr=entry sel, tbl_data=packed entry. All are registered outputs.
    - If vblank=0, go to WAIT_VB with no pop.
    - If count==0 (after this cycle's pop and push), go to IDLE.
- Drain rate: one pop per cycle. tbl_we is never high in a cycle following a non-pop cycle. tbl_addr and tbl_data hold their last values when tbl_we=0.
- Latency: push at edge N with vblank already high → first tbl_we in the cycle after edge N+2 (edge N+1 moves WAIT_VB to DRAIN, pop at edge N+2).
- Simultaneous push and pop: both take effect and count is unchanged. Push is gated only by count<DEPTH (see push-while-full rule).
- Ordering: strict FIFO. Multiple writes to the same sprite are all applied in order, so the last one wins.
- vblank falling mid-drain: the pop in that cycle does not occur. Remaining entries stay queued until the next vblank.
- pending = count register.

Optional Feature:
- Macro: SCHED_COALESCE_EN.
- Defined: a push whose sprite_sel equals the sel of the most recently pushed entry still queued overwrites that entry in place. Count and tail are unchanged. The push is accepted even when full, with no ovf and no stall effect that cycle.
  - Exception: if that entry is being popped in the same cycle, the push is appended normally.
- Undefined: every accepted push appends a new entry.

Test Plan:
- Reset, then push sel=3,x=100,y=50,vis=1 with vblank=0 → pending=1, tbl_we stays 0. Raise vblank → one tbl_we pulse, tbl_addr=3, tbl_data={1,0,0,9'd50,10'd100}, pending=0, state IDLE.
- Push 8 writes (sel 0..7) with vblank=0 → stall=1, pending=8. A 9th push → dropped, ovf=1. Pulse ovf_clr → ovf=0.
- With 8 queued, hold vblank high for 3 cycles → exactly 3 tbl_we pulses (sel 0,1,2), pending=5. Raise vblank again → sel 3..7 in order.
- Push on the same edge as a pop during DRAIN → pending unchanged; the new entry drains after the older entries, and tbl_we stays high every cycle.
- Assert reset in the middle of a drain → next cycle tbl_we=0, pending=0, ovf=0; later vblank produces no writes.
- With SCHED_COALESCE_EN: push sel=5,x=10 then sel=5,x=20 with vblank=0 → pending=1, and the drain writes x=20 only.
